// File: rtl/seg_scan_capture.sv
// Monitors a multiplexed active-low 7-segment bus and recovers the hex nibble shown on each of 4 digits.
// {an,seg} is synchronized, qualified by a stability window, then decoded once per stable window.
module seg_scan_capture #(
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        update,
    output logic        err_seg,
    output logic        err_an,
    output logic        frame_done
);

    logic [10:0]      s1, s2, prev;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       seen;
    logic             sample;

    logic [3:0]       an_s;
    logic             an_blank;
    logic             an_single;
    logic [1:0]       an_idx;
    logic             dec_ok;
    logic [3:0]       dec_nib;
    logic [3:0]       old_nib;
    logic [3:0]       seen_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= '1;
            s2   <= '1;
            prev <= '1;
            cnt  <= '0;
        end else begin
            s1   <= {an, seg};
            s2   <= s1;
            prev <= s2;
            if (s2 != prev)
                cnt <= '0;
            else if (cnt < CNT_W'(STABLE_CYCLES))
                cnt <= cnt + CNT_W'(1);
        end
    end

    // Only the edge where cnt reaches the threshold samples, so one event per stable window.
    assign sample = (s2 == prev) && (cnt == CNT_W'(STABLE_CYCLES - 1));

    assign an_s = prev[10:7];

    always_comb begin
        an_blank  = 1'b0;
        an_single = 1'b0;
        an_idx    = 2'd0;
        case (an_s)
            4'b1111: an_blank = 1'b1;
            4'b1110: begin an_single = 1'b1; an_idx = 2'd0; end
            4'b1101: begin an_single = 1'b1; an_idx = 2'd1; end
            4'b1011: begin an_single = 1'b1; an_idx = 2'd2; end
            4'b0111: begin an_single = 1'b1; an_idx = 2'd3; end
            default: ;
        endcase
    end

    always_comb begin
        dec_ok  = 1'b1;
        dec_nib = 4'h0;
        case (prev[6:0])
            7'b1000000: dec_nib = 4'h0;
            7'b1111001: dec_nib = 4'h1;
            7'b0100100: dec_nib = 4'h2;
            7'b0110000: dec_nib = 4'h3;
            7'b0011001: dec_nib = 4'h4;
            7'b0010010: dec_nib = 4'h5;
            7'b0000010: dec_nib = 4'h6;
            7'b1111000: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0010000: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b0000011: dec_nib = 4'hB;
            7'b1000110: dec_nib = 4'hC;
            7'b0100001: dec_nib = 4'hD;
            7'b0000110: dec_nib = 4'hE;
            7'b0001110: dec_nib = 4'hF;
            default:    dec_ok  = 1'b0;
        endcase
    end

    assign old_nib = digits[{an_idx, 2'b00} +: 4];
    assign seen_nx = seen | (4'b0001 << an_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= '0;
            digit_valid <= '0;
            seen        <= '0;
            update      <= 1'b0;
            err_seg     <= 1'b0;
            err_an      <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            update     <= 1'b0;
            err_seg    <= 1'b0;
            err_an     <= 1'b0;
            frame_done <= 1'b0;
            if (sample && !an_blank) begin
                if (!an_single) begin
                    err_an <= 1'b1;
                end else if (!dec_ok) begin
                    err_seg <= 1'b1;
                end else begin
                    digits[{an_idx, 2'b00} +: 4] <= dec_nib;
                    digit_valid[an_idx]          <= 1'b1;
                    update <= (old_nib != dec_nib) || !digit_valid[an_idx];
                    // A completed frame restarts collection so the next pulse needs 4 fresh captures.
                    if (seen_nx == 4'b1111) begin
                        frame_done <= 1'b1;
                        seen       <= '0;
                    end else begin
                        seen <= seen_nx;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed scenarios plus random pin traffic, checked every cycle
// against a pin-level model (a value seen at 9 consecutive edges is decoded 2 edges later).
module tb_seg_scan_capture;

  localparam int HOLD_MIN = 9;  // STABLE_CYCLES + 1 edges of a constant input value

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an = 4'hf;
  logic [6:0]  seg = 7'h7f;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        update, err_seg, err_an, frame_done;

  always #5 clk = ~clk;

  seg_scan_capture #(.STABLE_CYCLES(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg),
    .digits(digits), .digit_valid(digit_valid), .update(update),
    .err_seg(err_seg), .err_an(err_an), .frame_done(frame_done)
  );

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic [6:0]  code_tab[16];
  logic [3:0]  m_dig[4];
  logic [3:0]  m_valid, m_seen;
  logic        m_upd, m_eseg, m_ean, m_frame;
  logic [10:0] cur_v;
  int          run_len;
  int          edge_no = 0;
  logic [10:0] exp_q[$];
  int          exp_edge_q[$];
  int          n_upd, n_eseg, n_ean, n_frame;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
    m_valid = 4'h0; m_seen = 4'h0;
    m_upd = 0; m_eseg = 0; m_ean = 0; m_frame = 0;
    cur_v = 11'h7ff;
    run_len = HOLD_MIN;
    exp_q.delete();
    exp_edge_q.delete();
  endtask

  task automatic model_sample(input logic [10:0] v);
    logic [3:0] a;
    int lows, pos, nib;
    a = v[10:7];
    lows = $countones(~a);
    if (lows > 1) begin
      m_ean = 1;
    end else if (lows == 1) begin
      pos = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) pos = i;
      nib = -1;
      for (int k = 0; k < 16; k++) if (code_tab[k] == v[6:0]) nib = k;
      if (nib < 0) begin
        m_eseg = 1;
      end else begin
        if (!m_valid[pos] || m_dig[pos] != 4'(nib)) m_upd = 1;
        m_dig[pos] = 4'(nib);
        m_valid[pos] = 1;
        m_seen[pos] = 1;
        if (m_seen == 4'hf) begin
          m_frame = 1;
          m_seen = 4'h0;
        end
      end
    end
  endtask

  task automatic model_edge();
    logic [10:0] pins;
    edge_no++;
    m_upd = 0; m_eseg = 0; m_ean = 0; m_frame = 0;
    if (exp_edge_q.size() > 0 && exp_edge_q[0] == edge_no) begin
      void'(exp_edge_q.pop_front());
      model_sample(exp_q.pop_front());
    end
    pins = {an, seg};
    if (pins == cur_v) begin
      if (run_len < HOLD_MIN) begin
        run_len++;
        if (run_len == HOLD_MIN) begin
          exp_q.push_back(cur_v);
          exp_edge_q.push_back(edge_no + 2);
        end
      end
    end else begin
      cur_v = pins;
      run_len = 1;
    end
  endtask

  task automatic check_outputs();
    check_eq("digits", 32'(digits), 32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
    check_eq("digit_valid", 32'(digit_valid), 32'(m_valid));
    check_eq("update", 32'(update), 32'(m_upd));
    check_eq("err_seg", 32'(err_seg), 32'(m_eseg));
    check_eq("err_an", 32'(err_an), 32'(m_ean));
    check_eq("frame_done", 32'(frame_done), 32'(m_frame));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_outputs();
    n_upd += int'(update);
    n_eseg += int'(err_seg);
    n_ean += int'(err_an);
    n_frame += int'(frame_done);
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a;
    seg = s;
    repeat (n) tick();
  endtask

  task automatic clr_counts();
    n_upd = 0; n_eseg = 0; n_ean = 0; n_frame = 0;
  endtask

  initial begin
    logic [3:0] ra, one;
    logic [6:0] rs;
    int hl;

    code_tab[0]  = 7'b1000000; code_tab[1]  = 7'b1111001; code_tab[2]  = 7'b0100100;
    code_tab[3]  = 7'b0110000; code_tab[4]  = 7'b0011001; code_tab[5]  = 7'b0010010;
    code_tab[6]  = 7'b0000010; code_tab[7]  = 7'b1111000; code_tab[8]  = 7'b0000000;
    code_tab[9]  = 7'b0010000; code_tab[10] = 7'b0001000; code_tab[11] = 7'b0000011;
    code_tab[12] = 7'b1000110; code_tab[13] = 7'b0100001; code_tab[14] = 7'b0000110;
    code_tab[15] = 7'b0001110;
    model_reset();
    clr_counts();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // single digit, hold beyond the window
    hold(4'b1110, code_tab[2], 20);
    check_eq("t2_update_count", n_upd, 1);
    check_eq("t2_digit0", 32'(digits[3:0]), 2);
    hold(4'b1110, code_tab[2], 15);
    check_eq("t2_no_second_update", n_upd, 1);

    // full scan 1,2,3,4 then the same scan again
    clr_counts();
    for (int d = 0; d < 4; d++) begin
      one = 4'b0001 << d;
      hold(~one, code_tab[d + 1], 64);
    end
    check_eq("t3_digits", 32'(digits), 32'h4321);
    check_eq("t3_update_count", n_upd, 4);
    check_eq("t3_frame_count", n_frame, 1);
    clr_counts();
    for (int d = 0; d < 4; d++) begin
      one = 4'b0001 << d;
      hold(~one, code_tab[d + 1], 64);
    end
    check_eq("t3_rescan_updates", n_upd, 0);
    check_eq("t3_rescan_frames", n_frame, 1);

    // illegal segment pattern, then multi-select anode, then blank
    clr_counts();
    hold(4'b1110, 7'b1111111, 20);
    check_eq("t4_err_seg_count", n_eseg, 1);
    check_eq("t4_digit0_kept", 32'(digits[3:0]), 1);
    clr_counts();
    hold(4'b1100, code_tab[0], 20);
    check_eq("t5_err_an_count", n_ean, 1);
    clr_counts();
    hold(4'b1111, code_tab[0], 20);
    check_eq("t5_blank_pulses", n_upd + n_eseg + n_ean + n_frame, 0);

    // glitch inside a stable window
    hold(4'b1110, code_tab[2], 20);
    clr_counts();
    hold(4'b1110, code_tab[5], 5);
    hold(4'b1110, code_tab[2], 20);
    check_eq("t6_glitch_updates", n_upd, 0);
    check_eq("t6_digit0", 32'(digits[3:0]), 2);

    // asynchronous reset in the middle of a capture
    hold(4'b1101, code_tab[7], 6);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) tick();
    rst_n = 1'b1;
    hold(4'b1101, code_tab[7], 20);

    // random traffic, including holds around the sampling threshold
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 9))
        0: ra = 4'hf;
        1, 2: begin
          ra = 4'($urandom_range(0, 15));
          while ($countones(~ra) < 2) ra = 4'($urandom_range(0, 15));
        end
        default: begin
          one = 4'b0001 << $urandom_range(0, 3);
          ra = ~one;
        end
      endcase
      if ($urandom_range(0, 4) == 0) rs = 7'($urandom_range(0, 127));
      else rs = code_tab[$urandom_range(0, 15)];
      if ($urandom_range(0, 3) == 0) hl = $urandom_range(1, 11);
      else hl = $urandom_range(9, 30);
      hold(ra, rs, hl);
    end
    hold(4'hf, 7'h7f, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
